// File: rtl/fifo_pkg.sv
// Shared definitions for the FIFO read and write controllers: widths, state
// encoding of the output stage and pointer arithmetic helpers.
package fifo_pkg;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;
    localparam int PTR_W  = ADDR_W + 1;
    localparam int DEPTH  = 1 << ADDR_W;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } rd_state_e;

    // Pointers carry one extra wrap bit, so plain modulo subtraction gives occupancy.
    function automatic logic [PTR_W-1:0] ptrDiff(input logic [PTR_W-1:0] head,
                                                 input logic [PTR_W-1:0] tail);
        return head - tail;
    endfunction

    function automatic logic ptrOverrun(input logic [PTR_W-1:0] diff);
        return diff[PTR_W-1] && (diff[ADDR_W-1:0] != '0);
    endfunction

endpackage

// File: rtl/fifo_out_stage.sv
// Registered data/valid output stage of the FIFO read side. Holds one word
// and keeps it stable until the downstream side consumes it.
module fifo_out_stage
    import fifo_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              load_i,
    input  logic              consume_i,
    input  logic              flush_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [DATA_W-1:0] data_o,
    output logic              valid_o
);

    rd_state_e         state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
        end
    end

    // Flush drops the held word; a load replaces it; an accepted word with nothing behind it empties the stage.
    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        if (flush_i) begin
            state_d = IDLE;
        end else if (load_i) begin
            state_d = HOLD;
            data_d  = data_i;
        end else if ((state_q == HOLD) && consume_i) begin
            state_d = IDLE;
        end
    end

    assign data_o  = data_q;
    assign valid_o = (state_q == HOLD);

endmodule

// File: rtl/fifo_read_ctrl.sv
// Read-side controller of the 16x8 FIFO: owns the read pointer, derives empty,
// level and pointer-error status, and feeds the registered output stream.
module fifo_read_ctrl
    import fifo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic [PTR_W-1:0]  wptr,
    input  logic [DATA_W-1:0] mem_data,
    output logic [PTR_W-1:0]  rptr,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    input  logic              m_ready,
    input  logic              flush,
    output logic              fifo_empty,
    output logic [PTR_W-1:0]  fifo_level,
    output logic              ptr_err
);

    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic             ptrErr_q, ptrErr_d;
    logic             loadEn;

    assign fifo_empty = (wptr == rptr_q);
    assign fifo_level = ptrDiff(wptr, rptr_q);

    // A fetch happens whenever a word is stored and the output register is free or being drained.
    assign loadEn = !flush && !fifo_empty && (!m_valid || m_ready);

    always_comb begin
        rptr_d   = rptr_q;
        ptrErr_d = ptrErr_q | ptrOverrun(fifo_level);
        if (flush) begin
            rptr_d = wptr;
        end else if (loadEn) begin
            rptr_d = rptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rptr_q   <= '0;
            ptrErr_q <= 1'b0;
        end else begin
            rptr_q   <= rptr_d;
            ptrErr_q <= ptrErr_d;
        end
    end

    fifo_out_stage u_out_stage (
        .clk_i     (clk),
        .rst_i     (rst),
        .load_i    (loadEn),
        .consume_i (m_ready),
        .flush_i   (flush),
        .data_i    (mem_data),
        .data_o    (m_data),
        .valid_o   (m_valid)
    );

    assign rptr    = rptr_q;
    assign ptr_err = ptrErr_q;

endmodule
